dma_m2s_sched: RTL and testbench

Descriptor scheduler that sequences an M2S DMA engine. It queues (offset, byte-count) descriptors and issues them one at a time on a command handshake. It then monitors the engine's AXI-stream output and checks the beat count and TLAST against each descriptor. It sits between the host/control path and the M2S engine, and reports completion and framing errors.

---
 rtl/dma_m2s_sched.sv | 161 ++++++++++++++++
 tb/tb_dma_m2s_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_m2s_sched.sv
// Descriptor scheduler for an M2S DMA engine: queues (offset, bytes) descriptors,
// issues them as commands and checks the engine's stream framing for each one.
module dma_m2s_sched #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [ADDR_WIDTH-1:0] desc_offset,
  input  logic [LEN_WIDTH-1:0]  desc_bytes,
  input  logic                  desc_eol,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_offset,
  output logic [LEN_WIDTH-1:0]  cmd_bytes,
  input  logic                  mon_valid,
  input  logic                  mon_ready,
  input  logic                  mon_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  err_clr,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  localparam int BPB   = BUS_WIDTH / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LEN_WIDTH:0] BPB_W  = (LEN_WIDTH+1)'(BPB);
  localparam logic [LEN_WIDTH:0] BPB_M1 = (LEN_WIDTH+1)'(BPB - 1);
  localparam logic [LEN_WIDTH:0] BEAT_ONE = (LEN_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, STREAM} state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] fifo_offset [DEPTH];
  logic [LEN_WIDTH-1:0]  fifo_bytes  [DEPTH];
  logic                  fifo_eol    [DEPTH];
  logic [PTR_W:0]        wr_ptr, rd_ptr;
  logic                  full, empty, push, pop;

  logic [ADDR_WIDTH-1:0] head_offset;
  logic [LEN_WIDTH-1:0]  head_bytes;
  logic                  head_eol;

  logic [LEN_WIDTH:0]    exp_beats, beat_cnt;
  logic                  eol_r;

  logic beat, last_hit, load_cmd, complete, done_set, err_set, cnt_inc;

  function automatic logic [LEN_WIDTH:0] ceil_beats(input logic [LEN_WIDTH-1:0] b);
    return ({1'b0, b} + BPB_M1) / BPB_W;
  endfunction

  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign desc_ready = !full;
  assign push  = desc_valid && !full;
  assign pop   = (state == IDLE) && !empty;
  assign busy  = (state != IDLE) || !empty;

  assign head_offset = fifo_offset[rd_ptr[PTR_W-1:0]];
  assign head_bytes  = fifo_bytes[rd_ptr[PTR_W-1:0]];
  assign head_eol    = fifo_eol[rd_ptr[PTR_W-1:0]];

  // Descriptor storage: data only, pointers carry the reset
  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_offset[wr_ptr[PTR_W-1:0]] <= desc_offset;
      fifo_bytes[wr_ptr[PTR_W-1:0]]  <= desc_bytes;
      fifo_eol[wr_ptr[PTR_W-1:0]]    <= desc_eol;
    end
  end

  always_comb begin
    state_nxt = state;
    load_cmd  = 1'b0;
    complete  = 1'b0;
    done_set  = 1'b0;
    err_set   = 1'b0;
    cnt_inc   = 1'b0;
    beat      = mon_valid && mon_ready;
    last_hit  = (beat_cnt + BEAT_ONE) == exp_beats;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (head_bytes == '0) begin
            complete = 1'b1;
            done_set = head_eol;
          end else begin
            load_cmd  = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        // A stream before the command is accepted is a framing fault
        if (beat) err_set = 1'b1;
        if (cmd_ready) state_nxt = STREAM;
      end
      STREAM: begin
        if (beat) begin
          if (mon_last || last_hit) begin
            complete  = 1'b1;
            done_set  = eol_r;
            err_set   = (mon_last != last_hit);
            state_nxt = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cmd_valid  <= 1'b0;
      cmd_offset <= '0;
      cmd_bytes  <= '0;
      exp_beats  <= '0;
      beat_cnt   <= '0;
      eol_r      <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      xfer_count <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (load_cmd) begin
        cmd_valid  <= 1'b1;
        cmd_offset <= head_offset;
        cmd_bytes  <= head_bytes;
        exp_beats  <= ceil_beats(head_bytes);
        eol_r      <= head_eol;
      end else if (state == ISSUE && cmd_ready) begin
        cmd_valid <= 1'b0;
        beat_cnt  <= '0;
      end else if (cnt_inc) begin
        beat_cnt <= beat_cnt + BEAT_ONE;
      end
      done <= complete && done_set;
      if (complete) xfer_count <= xfer_count + CNT_ONE;
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_m2s_sched.sv
// Bench for dma_m2s_sched: directed vector table, multi-cycle corner sequences and
// a randomized descriptor stream scored against a queue-level model.
module tb_dma_m2s_sched;

  localparam int AW = 32, LW = 16, CW = 16, BPB = 4, NRND = 12;

  logic          aclk = 1'b0;
  logic          areset;
  logic          desc_valid, desc_ready, desc_eol;
  logic [AW-1:0] desc_offset, cmd_offset;
  logic [LW-1:0] desc_bytes, cmd_bytes;
  logic          cmd_valid, cmd_ready;
  logic          mon_valid, mon_ready, mon_last;
  logic          busy, done, err, err_clr;
  logic [CW-1:0] xfer_count;

  dma_m2s_sched #(.BUS_WIDTH(32), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DEPTH(4), .CNT_WIDTH(CW)) dut (
    .aclk(aclk), .areset(areset),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_offset(desc_offset),
    .desc_bytes(desc_bytes), .desc_eol(desc_eol),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_offset(cmd_offset), .cmd_bytes(cmd_bytes),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_last(mon_last),
    .busy(busy), .done(done), .err(err), .err_clr(err_clr), .xfer_count(xfer_count)
  );

  always #5 aclk = ~aclk;

  int total = 0, bad = 0;
  int done_seen = 0, cmdv_cycles = 0, exp_xfer = 0;

  always @(negedge aclk) begin
    if (done) done_seen++;
    if (cmd_valid) cmdv_cycles++;
  end

  typedef struct {
    logic [AW-1:0] off;
    logic [LW-1:0] bytes;
    logic          eol;
    int            nbeats;
    logic          last;
    logic          exp_err;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int ceil_div(input int b);
    return (b + BPB - 1) / BPB;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic push(input logic [AW-1:0] off, input logic [LW-1:0] b, input logic eol);
    int n;
    n = 0;
    while (!desc_ready && n < 400) begin
      @(negedge aclk);
      n++;
    end
    if (!desc_ready) begin
      chk("push_timeout", desc_ready, 1);
      return;
    end
    desc_valid = 1'b1; desc_offset = off; desc_bytes = b; desc_eol = eol;
    @(negedge aclk);
    desc_valid = 1'b0;
  endtask

  task automatic serve_cmd(input logic [AW-1:0] off, input logic [LW-1:0] b, input int hold);
    int n;
    n = 0;
    while (!cmd_valid && n < 400) begin
      @(negedge aclk);
      n++;
    end
    chk("cmd_valid", cmd_valid, 1);
    if (!cmd_valid) return;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", cmd_valid, 1);
      chk("hold_offset", cmd_offset, off);
      chk("hold_bytes", cmd_bytes, b);
      @(negedge aclk);
    end
    chk("cmd_offset", cmd_offset, off);
    chk("cmd_bytes", cmd_bytes, b);
    cmd_ready = 1'b1;
    @(negedge aclk);
    cmd_ready = 1'b0;
    chk("cmd_drop", cmd_valid, 0);
  endtask

  task automatic stream(input int n, input int last_pos, input int pct);
    int cnt, guard;
    logic v, r;
    cnt = 0; guard = 0;
    while (cnt < n && guard < 3000) begin
      v = ($urandom_range(99) < pct);
      r = (pct >= 100) ? 1'b1 : 1'($urandom_range(1));
      mon_valid = v; mon_ready = r; mon_last = (cnt + 1 == last_pos);
      @(negedge aclk);
      if (v && r) cnt++;
      guard++;
    end
    mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;
    if (cnt < n) chk("stream_timeout", cnt, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, c0, eol_sum;
    logic [AW-1:0] roff [NRND];
    logic [LW-1:0] rbytes [NRND];
    logic          reol [NRND];

    vt[0] = '{32'h100, 16'd10, 1'b1, 3, 1'b1, 1'b0};
    vt[1] = '{32'h200, 16'd8,  1'b0, 1, 1'b1, 1'b1};
    vt[2] = '{32'h300, 16'd4,  1'b1, 1, 1'b0, 1'b1};
    vt[3] = '{32'h400, 16'd0,  1'b1, 0, 1'b0, 1'b0};
    vt[4] = '{32'h500, 16'd1,  1'b0, 1, 1'b1, 1'b0};
    vt[5] = '{32'h600, 16'd16, 1'b1, 4, 1'b1, 1'b0};
    vt[6] = '{32'h700, 16'd7,  1'b0, 2, 1'b1, 1'b0};
    vt[7] = '{32'h800, 16'd12, 1'b1, 3, 1'b0, 1'b1};

    areset = 1'b1;
    desc_valid = 0; desc_offset = '0; desc_bytes = '0; desc_eol = 0;
    cmd_ready = 0; mon_valid = 0; mon_ready = 0; mon_last = 0; err_clr = 0;
    wait_cycles(3);
    areset = 1'b0;
    wait_cycles(1);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_offset", cmd_offset, 0);
    chk("rst_cmd_bytes", cmd_bytes, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_xfer", xfer_count, 0);
    chk("rst_desc_ready", desc_ready, 1);

    for (int i = 0; i < 8; i++) begin
      d0 = done_seen; c0 = cmdv_cycles;
      push(vt[i].off, vt[i].bytes, vt[i].eol);
      if (vt[i].bytes != 0) begin
        serve_cmd(vt[i].off, vt[i].bytes, 0);
        stream(vt[i].nbeats, vt[i].last ? vt[i].nbeats : 0, 100);
      end
      wait_cycles(3);
      exp_xfer++;
      chk("tbl_xfer", xfer_count, exp_xfer);
      chk("tbl_err", err, vt[i].exp_err);
      chk("tbl_done", done_seen - d0, vt[i].eol);
      chk("tbl_busy", busy, 0);
      if (vt[i].bytes == 0) chk("tbl_zero_nocmd", cmdv_cycles - c0, 0);
      if (vt[i].exp_err) begin
        err_clr = 1'b1;
        @(negedge aclk);
        err_clr = 1'b0;
        chk("err_clr", err, 0);
      end
    end

    // Command back-pressure, then sparse random stream handshakes
    d0 = done_seen;
    push(32'h1000, 16'd20, 1'b1);
    serve_cmd(32'h1000, 16'd20, 5);
    stream(4, 0, 20);
    wait_cycles(2);
    chk("bp_no_early_xfer", xfer_count, exp_xfer);
    chk("bp_busy", busy, 1);
    stream(1, 1, 20);
    wait_cycles(3);
    exp_xfer++;
    chk("bp_xfer", xfer_count, exp_xfer);
    chk("bp_done", done_seen - d0, 1);
    chk("bp_err", err, 0);

    // FIFO fill with the engine stalled
    d0 = done_seen;
    for (int i = 0; i < 5; i++) push(32'h2000 + 32'(i * 16), 16'd4, i == 4);
    chk("full_ready", desc_ready, 0);
    chk("full_busy", busy, 1);
    serve_cmd(32'h2000, 16'd4, 0);
    stream(1, 1, 100);
    wait_cycles(2);
    chk("full_ready_back", desc_ready, 1);
    for (int i = 1; i < 5; i++) begin
      serve_cmd(32'h2000 + 32'(i * 16), 16'd4, 0);
      stream(1, 1, 100);
    end
    wait_cycles(3);
    exp_xfer += 5;
    chk("full_xfer", xfer_count, exp_xfer);
    chk("full_done", done_seen - d0, 1);
    chk("full_err", err, 0);

    // Randomized descriptors against the queue model
    eol_sum = 0;
    for (int i = 0; i < NRND; i++) begin
      roff[i]   = $urandom;
      rbytes[i] = LW'($urandom_range(20));
      reol[i]   = 1'($urandom_range(1));
      if (reol[i]) eol_sum++;
    end
    d0 = done_seen;
    fork
      begin
        for (int i = 0; i < NRND; i++) push(roff[i], rbytes[i], reol[i]);
      end
      begin
        for (int j = 0; j < NRND; j++) begin
          if (rbytes[j] != 0) begin
            serve_cmd(roff[j], rbytes[j], $urandom_range(3));
            stream(ceil_div(int'(rbytes[j])), ceil_div(int'(rbytes[j])), 20);
          end
        end
      end
    join
    wait_cycles(6);
    exp_xfer += NRND;
    chk("rnd_xfer", xfer_count, exp_xfer);
    chk("rnd_done", done_seen - d0, eol_sum);
    chk("rnd_err", err, 0);
    chk("rnd_busy", busy, 0);

    // Stream beat during ISSUE, then reset in the middle of STREAM
    push(32'h3000, 16'd16, 1'b1);
    wait_cycles(1);
    chk("issue_cmd_valid", cmd_valid, 1);
    mon_valid = 1'b1; mon_ready = 1'b1;
    @(negedge aclk);
    mon_valid = 1'b0; mon_ready = 1'b0;
    chk("issue_beat_err", err, 1);
    serve_cmd(32'h3000, 16'd16, 0);
    push(32'h3100, 16'd4, 1'b1);
    push(32'h3200, 16'd4, 1'b1);
    stream(2, 0, 100);
    chk("pre_rst_busy", busy, 1);
    #2 areset = 1'b1;
    #1;
    chk("mid_rst_cmd_valid", cmd_valid, 0);
    chk("mid_rst_cmd_offset", cmd_offset, 0);
    chk("mid_rst_cmd_bytes", cmd_bytes, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_xfer", xfer_count, 0);
    chk("mid_rst_ready", desc_ready, 1);
    @(negedge aclk);
    areset = 1'b0;
    exp_xfer = 0;
    c0 = cmdv_cycles;
    stream(4, 4, 100);
    wait_cycles(3);
    chk("post_rst_xfer", xfer_count, exp_xfer);
    chk("post_rst_err", err, 0);
    chk("post_rst_nocmd", cmdv_cycles - c0, 0);
    chk("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
